// File: rtl/block_store_pkg.sv
// Shared widths, record layout and FSM encoding for the block record store.
// Records are packed {occ, colour, orient, y, x} from MSB down to LSB.
package block_store_pkg;

    localparam int X_W_DEF   = 8;
    localparam int Y_W_DEF   = 7;
    localparam int COL_W_DEF = 3;

    localparam logic [1:0] ST_CLEAR = 2'd0;
    localparam logic [1:0] ST_IDLE  = 2'd1;
    localparam logic [1:0] ST_SCAN  = 2'd2;

    function automatic int rec_y_lsb(int xw);
        return xw;
    endfunction

    function automatic int rec_orient_bit(int xw, int yw);
        return xw + yw;
    endfunction

    function automatic int rec_colour_lsb(int xw, int yw);
        return xw + yw + 1;
    endfunction

    function automatic int rec_occ_bit(int xw, int yw, int cw);
        return xw + yw + cw + 1;
    endfunction

    function automatic int rec_width(int xw, int yw, int cw);
        return xw + yw + cw + 2;
    endfunction

endpackage

// File: rtl/block_store_record_ram.sv
// Simple dual-port record RAM: one write port, one registered read port.
// Ports: clk; we/waddr/wdata write; re/raddr read request; rdata one cycle later.
module record_ram #(
    parameter int W     = 20,
    parameter int DEPTH = 32,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            // write-first: a same-cycle write to the read address wins
            if (we && (waddr == raddr)) begin
                rdata <= wdata;
            end else begin
                rdata <= mem[raddr];
            end
        end
    end

endmodule

// File: rtl/block_store.sv
// Block record store: clear-on-reset RAM with write/delete, read and full scan.
// Ports: clk/reset; wr_* write/delete; rd_en/rd_addr read; scan_* sweep; rd_* record out; count.
module block_store
    import block_store_pkg::*;
#(
    parameter int DEPTH  = 32,
    parameter int ADDR_W = $clog2(DEPTH),
    parameter int X_W    = X_W_DEF,
    parameter int Y_W    = Y_W_DEF,
    parameter int COL_W  = COL_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    output logic              ready,
    input  logic              wr_en,
    input  logic              wr_del,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [X_W-1:0]    wr_x,
    input  logic [Y_W-1:0]    wr_y,
    input  logic              wr_orient,
    input  logic [COL_W-1:0]  wr_colour,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_valid,
    input  logic              scan_start,
    output logic              scan_valid,
    output logic [ADDR_W-1:0] scan_addr,
    output logic              scan_done,
    output logic              rd_occ,
    output logic [X_W-1:0]    rd_x,
    output logic [Y_W-1:0]    rd_y,
    output logic              rd_orient,
    output logic [COL_W-1:0]  rd_colour,
    output logic [ADDR_W:0]   count
);

    localparam int Y_LSB   = rec_y_lsb(X_W);
    localparam int ORI_BIT = rec_orient_bit(X_W, Y_W);
    localparam int COL_LSB = rec_colour_lsb(X_W, Y_W);
    localparam int OCC_BIT = rec_occ_bit(X_W, Y_W, COL_W);
    localparam int REC_W   = rec_width(X_W, Y_W, COL_W);

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   ONE  = (ADDR_W + 1)'(1);

    logic [1:0]        state;
    logic [ADDR_W-1:0] clr_addr;
    logic [ADDR_W:0]   scan_ptr;
    logic [DEPTH-1:0]  occ;
    logic              scan_act;

    logic              idle;
    logic              in_clear;
    logic              in_scan;
    logic              wr_ok;
    logic              rd_ok;
    logic              scan_rd;

    logic              ram_we;
    logic              ram_re;
    logic [ADDR_W-1:0] ram_waddr;
    logic [ADDR_W-1:0] ram_raddr;
    logic [REC_W-1:0]  ram_wdata;
    logic [REC_W-1:0]  ram_rdata;

    assign idle     = (state == ST_IDLE);
    assign in_clear = (state == ST_CLEAR);
    assign in_scan  = (state == ST_SCAN);
    assign wr_ok    = idle & wr_en;
    assign rd_ok    = idle & rd_en;
    // the scan pointer runs one past the last address to drain the read
    assign scan_rd  = in_scan & ~scan_ptr[ADDR_W];

    assign ram_we    = in_clear | wr_ok;
    assign ram_waddr = in_clear ? clr_addr : wr_addr;
    assign ram_re    = rd_ok | scan_rd;
    assign ram_raddr = in_scan ? scan_ptr[ADDR_W-1:0] : rd_addr;

    always_comb begin
        ram_wdata = '0;
        if (wr_ok && !wr_del) begin
            ram_wdata = {1'b1, wr_colour, wr_orient, wr_y, wr_x};
        end
    end

    record_ram #(
        .W     (REC_W),
        .DEPTH (DEPTH),
        .AW    (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .re    (ram_re),
        .raddr (ram_raddr),
        .rdata (ram_rdata)
    );

    assign ready      = idle;
    assign rd_x       = ram_rdata[X_W-1:0];
    assign rd_y       = ram_rdata[Y_LSB +: Y_W];
    assign rd_orient  = ram_rdata[ORI_BIT];
    assign rd_colour  = ram_rdata[COL_LSB +: COL_W];
    assign rd_occ     = ram_rdata[OCC_BIT];
    assign scan_valid = scan_act & ram_rdata[OCC_BIT];
    assign scan_done  = scan_act & (scan_addr == LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_CLEAR;
            clr_addr  <= '0;
            scan_ptr  <= '0;
            occ       <= '0;
            count     <= '0;
            rd_valid  <= 1'b0;
            scan_act  <= 1'b0;
            scan_addr <= '0;
        end else begin
            rd_valid <= rd_ok;
            scan_act <= scan_rd;
            if (scan_rd) begin
                scan_addr <= scan_ptr[ADDR_W-1:0];
            end
            unique case (state)
                ST_CLEAR: begin
                    clr_addr <= clr_addr + 1'b1;
                    if (clr_addr == LAST) begin
                        state <= ST_IDLE;
                    end
                end
                ST_IDLE: begin
                    if (wr_ok) begin
                        occ[wr_addr] <= ~wr_del;
                        if (!wr_del && !occ[wr_addr]) begin
                            count <= count + ONE;
                        end else if (wr_del && occ[wr_addr]) begin
                            count <= count - ONE;
                        end
                    end
                    if (scan_start) begin
                        state    <= ST_SCAN;
                        scan_ptr <= '0;
                    end
                end
                ST_SCAN: begin
                    if (scan_ptr[ADDR_W]) begin
                        state <= ST_IDLE;
                    end else begin
                        scan_ptr <= scan_ptr + 1'b1;
                    end
                end
                default: begin
                    state <= ST_CLEAR;
                end
            endcase
        end
    end

endmodule
